// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: operand width,
// iteration-counter width, FSM state encoding and a magnitude helper used
// when signed operation is enabled (SEQ_MUL_SIGNED_EN).
package seq_mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  // IDLE -> CALC -> [NEG_LO -> NEG_HI] -> DONE -> IDLE
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    NEG_LO = 3'd2,
    NEG_HI = 3'd3,
    DONE   = 3'd4
  } mul_state_t;

  // Two's-complement magnitude; the most negative value maps to 2^31 read as unsigned
  function automatic logic [MUL_WIDTH-1:0] magnitude(input logic [MUL_WIDTH-1:0] value,
                                                     input logic                 take_abs);
    logic [MUL_WIDTH-1:0] mag;
    mag = value;
    if (take_abs && value[MUL_WIDTH-1]) begin
      mag = ~value + 1'b1;
    end
    return mag;
  endfunction

endpackage

// File: rtl/seq_mul32_cla.sv
// cla_adder32: 32-bit carry-lookahead adder built from eight 4-bit groups.
// Each group produces generate/propagate terms so the carry into the next
// group is resolved from group signals instead of rippling through every bit.
module cla_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] result,
  output logic        cout
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [32:0] carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Group lookahead for the carry into each nibble, then per-bit carries inside it
  always_comb begin
    logic grp_g;
    logic grp_p;
    carry    = '0;
    carry[0] = cin;
    for (int k = 0; k < 8; k++) begin
      grp_g = gen[4*k+3]
            | (prop[4*k+3] & gen[4*k+2])
            | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
            | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_p = &prop[4*k +: 4];
      carry[4*k+1] = gen[4*k]   | (prop[4*k]   & carry[4*k]);
      carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & carry[4*k+1]);
      carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & carry[4*k+2]);
      carry[4*k+4] = grp_g | (grp_p & carry[4*k]);
    end
  end

  assign result = prop ^ carry[31:0];
  assign cout   = carry[32];

endmodule

// File: rtl/seq_mul32.sv
// seq_mul32: iterative 32x32->64 shift-add multiplier, one multiplier bit per
// cycle through a single shared cla_adder32. Valid/ready on both sides; the
// product is registered and held until the consumer takes it.
// Optional feature: define SEQ_MUL_SIGNED_EN to honour signed_op (operands
// are reduced to magnitudes and the product is negated afterwards in the
// NEG_LO/NEG_HI states). Without it every multiply is unsigned.
module seq_mul32
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               signed_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  // The datapath is tied to the 32-bit adder, so other widths cannot work
  if (WIDTH != MUL_WIDTH) begin : g_bad_width
    $error("seq_mul32: WIDTH must be 32");
  end

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  mul_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic             last_iter;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_in;
  logic neg_q;
  logic carry_q;

  assign mag_a  = magnitude(op_a, signed_op);
  assign mag_b  = magnitude(op_b, signed_op);
  assign neg_in = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
  logic signed_op_unused;

  assign signed_op_unused = signed_op;
  assign mag_a            = op_a;
  assign mag_b            = op_b;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign last_iter = (cnt == LAST_ITER);

  cla_adder32 u_adder (
    .a      (add_a),
    .b      (add_b),
    .cin    (add_cin),
    .result (add_sum),
    .cout   (add_cout)
  );

  // State register, cleared to IDLE from any state on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed 32 CALC cycles, optional negate pass, hold DONE until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
`ifdef SEQ_MUL_SIGNED_EN
          state_nxt = neg_q ? NEG_LO : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SEQ_MUL_SIGNED_EN
      NEG_LO: state_nxt = NEG_HI;
      NEG_HI: state_nxt = DONE;
`endif
      DONE: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs per state: input handshake and the operands steered into the adder
  always_comb begin
    in_ready = 1'b0;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      CALC: begin
        add_a = acc_hi;
        add_b = acc_lo[0] ? mcand : '0;
      end
`ifdef SEQ_MUL_SIGNED_EN
      NEG_LO: begin
        add_a   = ~acc_lo;
        add_cin = 1'b1;
      end
      NEG_HI: begin
        add_a   = ~acc_hi;
        add_cin = carry_q;
      end
`endif
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, shift-add iteration and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= mag_a;
            acc_hi <= '0;
            acc_lo <= mag_b;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
          acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
`ifdef SEQ_MUL_SIGNED_EN
        NEG_LO: acc_lo <= add_sum;
        NEG_HI: acc_hi <= add_sum;
`endif
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

`ifdef SEQ_MUL_SIGNED_EN
  // Sign bookkeeping: remember whether to negate and the low-word carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        neg_q <= neg_in;
      end
      if (state == NEG_LO) begin
        carry_q <= add_cout;
      end
    end
  end
`endif

  // Result register: load once on entering DONE, hold until the consumer accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (state == DONE) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        product   <= {acc_hi, acc_lo};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul32.sv
// Directed self-checking bench for seq_mul32. Signed cases only run when
// SEQ_MUL_SIGNED_EN is defined; otherwise signed_op=1 must be ignored.
module tb_seq_mul32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        signed_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;
  int lat;
  int bad_ready;
  int bad_valid;
  int bad_stable;

  seq_mul32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .signed_op (signed_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one operand pair for a single cycle; returns #1 after the accept edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    signed_op = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges until out_valid, bounded so a stuck DUT still ends
  task automatic waitResult(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic popResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp_prod, input int exp_lat);
    int n;
    applyStimulus(a, b, s);
    checkOutput({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    waitResult(n);
    checkOutput({tag, "_latency"}, 64'(n), 64'(exp_lat));
    checkOutput({tag, "_product"}, product, exp_prod);
    popResult();
    checkOutput({tag, "_valid_after_pop"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, "_ready_after_pop"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    signed_op = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of CALC discards the operation
    $display("[TB] reset mid-calculation");
    applyStimulus(32'd9, 32'd9, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midrst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad_valid++;
    end
    checkOutput("midrst_no_pulse", 64'(bad_valid), 64'd0);
    runOp("after_rst_6x7", 32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A, 33);

    // Unsigned directed vectors
    $display("[TB] unsigned vectors");
    runOp("u_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 33);
    runOp("u_max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33);
    runOp("u_zero_mult", 32'hDEAD_BEEF, 32'd0, 1'b0, 64'h0000_0000_0000_0000, 33);
    runOp("u_msb_x2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 33);
    runOp("u_m1x2_s0", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 33);

    // Backpressure: in_valid during CALC ignored, product held while out_ready=0
    $display("[TB] backpressure");
    applyStimulus(32'h1234_5678, 32'h0000_0010, 1'b0);
    bad_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_a     = 32'hAAAA_AAAA;
      op_b     = 32'h5555_5555;
      @(posedge clk);
      #1;
      if (in_ready !== 1'b0) bad_ready++;
    end
    in_valid = 1'b0;
    checkOutput("bp_ready_in_calc", 64'(bad_ready), 64'd0);
    waitResult(lat);
    checkOutput("bp_latency_rest", 64'(lat), 64'd28);
    checkOutput("bp_product", product, 64'h0000_0001_2345_6780);
    bad_stable = 0;
    bad_ready  = 0;
    bad_valid  = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (product !== 64'h0000_0001_2345_6780) bad_stable++;
      if (in_ready !== 1'b0) bad_ready++;
      if (out_valid !== 1'b1) bad_valid++;
    end
    checkOutput("bp_product_stable", 64'(bad_stable), 64'd0);
    checkOutput("bp_ready_in_done", 64'(bad_ready), 64'd0);
    checkOutput("bp_valid_held", 64'(bad_valid), 64'd0);
    popResult();
    checkOutput("bp_valid_after_pop", {63'd0, out_valid}, 64'd0);
    checkOutput("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
    runOp("bp_next_op", 32'd100, 32'd1000, 1'b0, 64'd100000, 33);

`ifdef SEQ_MUL_SIGNED_EN
    // Signed multiply with negate pass
    $display("[TB] signed vectors");
    runOp("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 35);
    runOp("s_min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33);
    runOp("s_5xm4", 32'd5, 32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 35);
    runOp("s_m1x2_unsigned", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 33);
`else
    // Without signed support signed_op must not change anything
    $display("[TB] signed_op ignored");
    runOp("ns_m3x7_s1", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'h0000_0006_FFFF_FFEB, 33);
    runOp("ns_m1x2_s1", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE, 33);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
